// File: rtl/ripple_count_capture.sv
// ripple_count_capture: brings a 4-bit ripple counter output into the clk
// domain, filters ripple transients, extends the count to W bits by tracking
// wraps, flags non-unit steps, pulses on a terminal match and serves value
// snapshots over a req/valid/ack handshake.
// Optional feature: define RCC_GLITCH_FILTER_EN to add the s3 stability
// filter (3-cycle latency); without it cnt_q follows s2 (2-cycle latency).
module ripple_count_capture #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   cnt_in,
    input  logic         dir,
    input  logic [W-1:0] match_val,
    output logic [W-1:0] ext_cnt,
    output logic         cnt_valid,
    output logic         match_pulse,
    output logic         skip_err,
    input  logic         snap_req,
    input  logic         snap_ack,
    output logic         snap_valid,
    output logic [W-1:0] snap_data
);

    typedef enum logic {IDLE, HOLD} snap_state_t;

    localparam logic [W-5:0] EPOCH_ONE = 1;

    logic [3:0]   s1, s2, cnt_q;
    logic [W-5:0] epoch;
    // fill flags mark stages that carry a real post-reset sample, so the
    // reset value of the pipeline is never mistaken for a settled count
    logic         fill1, fill2;
`ifdef RCC_GLITCH_FILTER_EN
    logic [3:0]   s3;
    logic         fill3;
`endif

    logic         cand_ok;
    logic         upd;
    logic [3:0]   nxt_up, nxt_dn;
    logic [W-5:0] epoch_nxt;
    logic         skip_nxt;
    logic         snap_load;
    snap_state_t  state_q, state_d;

    assign ext_cnt = {epoch, cnt_q};

    // Two-flop synchronizer plus optional stability stage
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            fill1 <= 1'b0;
            fill2 <= 1'b0;
`ifdef RCC_GLITCH_FILTER_EN
            s3    <= '0;
            fill3 <= 1'b0;
`endif
        end else begin
            s1    <= cnt_in;
            s2    <= s1;
            fill1 <= 1'b1;
            fill2 <= fill1;
`ifdef RCC_GLITCH_FILTER_EN
            s3    <= s2;
            fill3 <= fill2;
`endif
        end
    end

    // Candidate acceptance, wrap tracking and step checking
    always_comb begin
`ifdef RCC_GLITCH_FILTER_EN
        cand_ok = fill3 && (s2 == s3);
`else
        cand_ok = fill2;
`endif
        upd       = cand_ok && (!cnt_valid || (s2 != cnt_q));
        nxt_up    = cnt_q + 4'd1;
        nxt_dn    = cnt_q - 4'd1;
        epoch_nxt = epoch;
        skip_nxt  = 1'b0;
        if (cnt_valid) begin
            if (!dir) begin
                if (s2 < cnt_q) epoch_nxt = epoch + EPOCH_ONE;
                skip_nxt = (s2 != nxt_up);
            end else begin
                if (s2 > cnt_q) epoch_nxt = epoch - EPOCH_ONE;
                skip_nxt = (s2 != nxt_dn);
            end
        end
    end

    // Extended count register, sticky skip flag and match pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            epoch       <= '0;
            cnt_valid   <= 1'b0;
            match_pulse <= 1'b0;
            skip_err    <= 1'b0;
        end else begin
            match_pulse <= upd && ({epoch_nxt, s2} == match_val);
            if (upd) begin
                cnt_q     <= s2;
                epoch     <= epoch_nxt;
                cnt_valid <= 1'b1;
                if (skip_nxt) skip_err <= 1'b1;
            end
        end
    end

    // Snapshot FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Snapshot FSM next-state and outputs; requests in HOLD are ignored
    always_comb begin
        state_d    = state_q;
        snap_load  = 1'b0;
        snap_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap_req) begin
                    snap_load = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                snap_valid = 1'b1;
                if (snap_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot capture takes the registered (pre-update) extended count
    always_ff @(posedge clk) begin
        if (reset)          snap_data <= '0;
        else if (snap_load) snap_data <= ext_cnt;
    end

endmodule

// File: tb/tb_ripple_count_capture.sv
// Self-checking bench for ripple_count_capture (W = 12). Honours
// RCC_GLITCH_FILTER_EN for the expected latency and glitch behaviour.
module tb_ripple_count_capture;

    localparam int unsigned W = 12;
`ifdef RCC_GLITCH_FILTER_EN
    localparam int unsigned LAT = 3;
    localparam bit          FILT = 1'b1;
`else
    localparam int unsigned LAT = 2;
    localparam bit          FILT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   cnt_in;
    logic         dir;
    logic [W-1:0] match_val;
    logic [W-1:0] ext_cnt;
    logic         cnt_valid;
    logic         match_pulse;
    logic         skip_err;
    logic         snap_req;
    logic         snap_ack;
    logic         snap_valid;
    logic [W-1:0] snap_data;

    ripple_count_capture #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cnt_in     (cnt_in),
        .dir        (dir),
        .match_val  (match_val),
        .ext_cnt    (ext_cnt),
        .cnt_valid  (cnt_valid),
        .match_pulse(match_pulse),
        .skip_err   (skip_err),
        .snap_req   (snap_req),
        .snap_ack   (snap_ack),
        .snap_valid (snap_valid),
        .snap_data  (snap_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         rst;
        logic [3:0] cnt;
        logic       d;
        int         mval;
        int         ext;
        bit         skip;
        int         pulses;
    } vec_t;

    vec_t vt[17];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // one clock, then settle 1 time unit past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int  p;
    int  saw6;
    int  m_ext;
    int  m_old;
    bit  m_skip;
    int  v;
    bit  d;
    int  expv;
    int  exp_p;

    initial begin
        reset     = 1'b0;
        cnt_in    = 4'd5;
        dir       = 1'b0;
        match_val = 12'h800;
        snap_req  = 1'b0;
        snap_ack  = 1'b0;

        vt[0]  = '{1, 4'd14, 0, 16,    14,   0, 0};
        vt[1]  = '{0, 4'd15, 0, 16,    15,   0, 0};
        vt[2]  = '{0, 4'd0,  0, 16,    16,   0, 1};
        vt[3]  = '{0, 4'd1,  0, 16,    17,   0, 0};
        vt[4]  = '{1, 4'd1,  0, 2048,  1,    0, 0};
        vt[5]  = '{0, 4'd0,  1, 2048,  0,    0, 0};
        vt[6]  = '{0, 4'd15, 1, 2048,  4095, 0, 0};
        vt[7]  = '{0, 4'd14, 1, 2048,  4094, 0, 0};
        vt[8]  = '{1, 4'd3,  0, 2048,  3,    0, 0};
        vt[9]  = '{0, 4'd6,  0, 2048,  6,    1, 0};
        vt[10] = '{0, 4'd7,  0, 2048,  7,    1, 0};
        vt[11] = '{1, 4'd2,  0, 2048,  2,    0, 0};
        vt[12] = '{0, 4'd3,  0, 2048,  3,    0, 0};
        vt[13] = '{0, 4'd2,  1, 2048,  2,    0, 0};
        vt[14] = '{0, 4'd1,  1, 2048,  1,    0, 0};
        vt[15] = '{0, 4'd0,  0, 2048,  16,   1, 0};
        vt[16] = '{1, 4'd9,  0, 9,     9,    0, 1};

        // reset state and priming latency
        reset = 1'b1;
        tick();
        check("rst_ext", int'(ext_cnt), 0);
        check("rst_cnt_valid", int'(cnt_valid), 0);
        check("rst_match", int'(match_pulse), 0);
        check("rst_skip", int'(skip_err), 0);
        check("rst_snap_valid", int'(snap_valid), 0);
        check("rst_snap_data", int'(snap_data), 0);
        tick();
        reset = 1'b0;
        repeat (LAT) tick();
        check("prime_early_valid", int'(cnt_valid), 0);
        tick();
        check("prime_valid", int'(cnt_valid), 1);
        check("prime_ext", int'(ext_cnt), 5);
        check("prime_skip", int'(skip_err), 0);
        check("prime_match", int'(match_pulse), 0);

        // update latency and single-cycle match pulse
        match_val = 12'd6;
        cnt_in    = 4'd6;
        repeat (LAT) tick();
        check("upd_early_ext", int'(ext_cnt), 5);
        check("upd_early_match", int'(match_pulse), 0);
        tick();
        check("upd_ext", int'(ext_cnt), 6);
        check("upd_match", int'(match_pulse), 1);
        tick();
        check("upd_match_fall", int'(match_pulse), 0);
        match_val = 12'd5;
        repeat (3) tick();
        check("mval_change_no_pulse", int'(match_pulse), 0);

        // table-driven sequences
        for (int i = 0; i < 17; i++) begin
            cnt_in    = vt[i].cnt;
            dir       = vt[i].d;
            match_val = 12'(vt[i].mval);
            if (vt[i].rst) do_reset();
            p = 0;
            repeat (8) begin
                tick();
                p += int'(match_pulse);
            end
            check($sformatf("vec%0d_ext", i), int'(ext_cnt), vt[i].ext);
            check($sformatf("vec%0d_skip", i), int'(skip_err), int'(vt[i].skip));
            check($sformatf("vec%0d_pulses", i), p, vt[i].pulses);
        end

        // ripple glitch 7 -> (6 for one cycle) -> 8
        cnt_in    = 4'd7;
        dir       = 1'b0;
        match_val = 12'h800;
        do_reset();
        repeat (8) tick();
        check("glitch_start", int'(ext_cnt), 7);
        saw6   = 0;
        cnt_in = 4'd6;
        tick();
        cnt_in = 4'd8;
        repeat (10) begin
            tick();
            if (ext_cnt[3:0] == 4'd6) saw6 = 1;
        end
        check("glitch_saw6", saw6, FILT ? 0 : 1);
        check("glitch_ext", int'(ext_cnt), FILT ? 8 : 24);
        check("glitch_skip", int'(skip_err), FILT ? 0 : 1);

        // snapshot handshake
        cnt_in = 4'd9;
        do_reset();
        repeat (8) tick();
        check("snap_pre_ext", int'(ext_cnt), 9);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check("snap_valid_rise", int'(snap_valid), 1);
        check("snap_data_first", int'(snap_data), 9);
        cnt_in = 4'd10;
        repeat (6) tick();
        check("snap_count_adv", int'(ext_cnt), 10);
        snap_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("snap_hold%0d_valid", k), int'(snap_valid), 1);
            check($sformatf("snap_hold%0d_data", k), int'(snap_data), 9);
        end
        snap_ack = 1'b1;
        tick();
        check("snap_ack_fall", int'(snap_valid), 0);
        snap_ack = 1'b0;
        tick();
        snap_req = 1'b0;
        check("snap_rereq_valid", int'(snap_valid), 1);
        check("snap_rereq_data", int'(snap_data), 10);
        snap_ack = 1'b1;
        tick();
        check("snap_ack2_fall", int'(snap_valid), 0);
        tick();
        snap_ack = 1'b0;
        check("snap_ack_idle", int'(snap_valid), 0);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check("snap_third_valid", int'(snap_valid), 1);
        reset = 1'b1;
        tick();
        check("snap_reset_valid", int'(snap_valid), 0);
        check("snap_reset_data", int'(snap_data), 0);
        tick();
        reset = 1'b0;

        // randomized steps against an arithmetic reference model
        v         = $urandom_range(0, 15);
        cnt_in    = 4'(v);
        dir       = 1'b0;
        match_val = 12'h800;
        do_reset();
        repeat (8) tick();
        m_ext  = v;
        m_old  = v;
        m_skip = 1'b0;
        check("rand_prime_ext", int'(ext_cnt), m_ext);
        for (int s = 0; s < 80; s++) begin
            d = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) v = $urandom_range(0, 15);
            else v = d ? (m_old + 15) % 16 : (m_old + 1) % 16;
            exp_p = 0;
            if (v != m_old) begin
                expv = d ? (m_old + 15) % 16 : (m_old + 1) % 16;
                if (v != expv) m_skip = 1'b1;
                if (!d && v < m_old) m_ext += 16;
                if (d && v > m_old) m_ext -= 16;
                m_ext = ((m_ext & ~15) | v) & ((1 << W) - 1);
                m_old = v;
                case ($urandom_range(0, 2))
                    0: match_val = 12'(m_ext);
                    1: match_val = 12'($urandom_range(0, 4095));
                    default: match_val = 12'((m_ext + 16) & 4095);
                endcase
                exp_p = (int'(match_val) == m_ext) ? 1 : 0;
            end else begin
                match_val = 12'(m_ext);
            end
            cnt_in = 4'(v);
            dir    = d;
            p = 0;
            repeat (6) begin
                tick();
                p += int'(match_pulse);
            end
            check($sformatf("rand%0d_ext", s), int'(ext_cnt), m_ext);
            check($sformatf("rand%0d_skip", s), int'(skip_err), int'(m_skip));
            check($sformatf("rand%0d_pulses", s), p, exp_p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ripple_count_capture.md
# ripple_count_capture

Brings the 4-bit output of a ripple (asynchronous) counter into the `clk` domain. Settles and filters the ripple transients, and extends the count to `W` bits by tracking wraps. Raises a terminal-match pulse and serves value snapshots over a req/valid/ack handshake. It sits directly downstream of the 4-bit ripple counter, whose `q[3:0]` drives `cnt_in`.

## Interface
Parameters:
- `W`, default 12: extended count width; legal range 5..32. The epoch field is `W-4` bits.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high reset.
- `cnt_in`, input, 4: ripple counter output; asynchronous to `clk`.
- `dir`, input, 1: counting direction of the source. 0 = up, 1 = down.
- `match_val`, input, W: terminal value for the compare.
- `ext_cnt`, output, W: extended count, `{epoch, cnt_q}`.
- `cnt_valid`, output, 1: high once the first value has been accepted after reset.
- `match_pulse`, output, 1: one-cycle pulse when `ext_cnt` becomes equal to `match_val`.
- `skip_err`, output, 1: sticky flag; a step other than ±1 was observed.
- `snap_req`, input, 1: snapshot request.
- `snap_ack`, input, 1: consumer accepts the snapshot.
- `snap_valid`, output, 1: `snap_data` holds a valid snapshot.
- `snap_data`, output, W: captured `ext_cnt`.

## Operation
- **Synchronizer:** 2-flop synchronizer per bit, `s1` → `s2`.
- **Filter:** `s3` holds the previous `s2`. A candidate is accepted when `s2 == s3` and `s2 != cnt_q`.
- **Priming:** the first accepted candidate after reset loads `cnt_q`, sets `cnt_valid`, keeps epoch at 0, and performs no wrap or skip check. While `cnt_valid = 0`, a value equal to the reset value 0 is also accepted.
- **Wrap rule, up (`dir = 0`):** if new < old, epoch += 1.
- **Wrap rule, down (`dir = 1`):** if new > old, epoch -= 1.
- Epoch arithmetic is modulo 2^(W-4), so `ext_cnt` wraps modulo 2^W.
- **Skip check:** the expected new value is (old+1) mod 16 for up, (old-1) mod 16 for down. Any other value sets `skip_err`. The value is still loaded and the wrap rule still applies. `skip_err` clears only on `reset`.
- `dir` is evaluated on the update cycle only. A direction change between updates is legal.
- **Match:** on an update cycle, `match_pulse` is asserted for exactly one cycle if the new `ext_cnt == match_val`. Equality with no update, or a change of `match_val`, does not pulse.
- **Snapshot FSM:**
  - States are `IDLE` and `HOLD`.
  - `IDLE` with `snap_req = 1`: `snap_data` ← current `ext_cnt` (the pre-update value if an update happens in the same cycle); go to `HOLD`.
  - `HOLD`: `snap_valid = 1` and `snap_data` is stable. With `snap_ack = 1`, return to `IDLE`.
  - `snap_req` is ignored in `HOLD`, including in the ack cycle. A new request is honoured no earlier than the cycle after `snap_valid` falls.
  - `snap_ack` in `IDLE` is ignored.
- **Reset:** all of the following are 0 after the reset edge, and the FSM is in `IDLE`. `reset` mid-operation abandons any snapshot with no ack required.
  - `s1`, `s2`, `s3`, `cnt_q`, epoch
  - `ext_cnt`, `cnt_valid`, `match_pulse`, `skip_err`
  - `snap_valid`, `snap_data`

## Timing
- Let N be the first `clk` edge that samples a settled `cnt_in`.
- `s2` holds the value after N+1.
- With the filter, `ext_cnt`, `cnt_valid` and `match_pulse` update at edge N+3.
- Without the filter, they update at edge N+2.
- `snap_valid` rises on the edge after `snap_req` is sampled in `IDLE`. It falls on the edge after `snap_ack` is sampled high.
- The source must hold each count for at least 4 `clk` cycles (3 without the filter). Faster sources produce `skip_err`.

## Configuration
- `RCC_GLITCH_FILTER_EN` defined: the `s3` stability filter is present, giving 3-cycle latency. Transient ripple codes lasting 1 cycle are rejected.
- Not defined: `s3` is removed and `cnt_q` loads `s2` whenever it differs, giving 2-cycle latency. All other behaviour is identical.

## Test plan
- **Reset/prime:** reset, then `cnt_in = 5` held → `cnt_valid = 1` and `ext_cnt = 5` at N+3; `skip_err = 0`, `match_pulse = 0`.
- **Up wrap:** `dir = 0`, step 14, 15, 0, 1 every 6 cycles → `ext_cnt` = 14, 15, 16, 17. With `W = 12`, `match_val = 16` → exactly one `match_pulse` when `ext_cnt` becomes 16.
- **Down wrap:** prime at 1, `dir = 1`, step 0, 15, 14 → `ext_cnt` = 0, 4095, 4094.
- **Ripple glitch:** transition 7 → 8 with an intermediate 6 held for 1 cycle → with the macro, `ext_cnt` goes 7 → 8 and `skip_err = 0`. Without the macro, `ext_cnt` passes through 6 and `skip_err = 1`.
- **Skip:** prime at 3, jump to 6 → `ext_cnt = 6` and `skip_err = 1`; the flag persists until `reset`.
- **Snapshot:**
  - With `ext_cnt = 9`, pulse `snap_req` → `snap_valid = 1` and `snap_data = 9` on the next cycle.
  - Count advances, a second `snap_req` arrives, and `snap_ack` is delayed 5 cycles → `snap_data` stays 9 throughout.
  - `snap_ack` → `snap_valid` = 0 on the next edge.
  - Assert `reset` while `snap_valid = 1` → `snap_valid` = 0 after the reset edge.
